// File: rtl/sd_emmc_sdma_walker_if.sv
// Beat handshake and address bus between the data FIFO/bus master and the SDMA walker.
// The walker owns the address; the data path owns beat_valid.
interface sd_emmc_sdma_walker_if;
   logic        beat_valid;
   logic        beat_ready;
   logic [31:0] mem_addr;

   modport master (
      output beat_valid,
      input  beat_ready,
      input  mem_addr
   );

   modport slave (
      input  beat_valid,
      output beat_ready,
      output mem_addr
   );
endinterface

// File: rtl/sd_emmc_sdma_walker.sv
// SDMA address walker: advances the system address per 32-bit beat, counts words/blocks,
// and pauses with a DMA interrupt at every buffer-boundary crossing until a new address is written.
module sd_emmc_sdma_walker #(
   parameter int unsigned BLKCNT_W  = 16,
   parameter int unsigned BLKSIZE_W = 12
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 stop,
   input  logic [31:0]          init_dma_sys_addr,
   input  logic                 sys_addr_wr,
   input  logic [31:0]          sys_addr_wdata,
   input  logic [2:0]           buf_boundary,
   input  logic [BLKSIZE_W-1:0] block_size,
   input  logic [BLKCNT_W-1:0]  block_count,
   input  logic                 blk_cnt_en,
   sd_emmc_sdma_walker_if.slave beat,
   output logic [BLKCNT_W-1:0]  blocks_left,
   output logic                 busy,
   output logic                 dma_int,
   output logic                 xfer_done
);

   localparam int unsigned WordW = BLKSIZE_W - 2;

   typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

   state_e              state_q;
   logic [31:0]         mem_addr_q;
   logic [BLKCNT_W-1:0] blocks_left_q;
   logic [2:0]          boundary_q;
   logic [WordW-1:0]    word_last_q;
   logic [WordW-1:0]    word_cnt_q;
   logic                dma_int_q;
   logic                xfer_done_q;

   logic [31:0] next_addr;
   logic [31:0] boundary_mask;
   logic        boundary_hit;
   logic        last_word;
   logic        last_beat;
   logic        unused_block_size;

   // Block size is a multiple of 4; the low bits carry no information.
   assign unused_block_size = ^block_size[1:0];

   assign next_addr     = mem_addr_q + 32'd4;
   assign boundary_mask = (32'h0000_1000 << boundary_q) - 32'd1;
   assign boundary_hit  = (next_addr & boundary_mask) == 32'd0;
   assign last_word     = (word_cnt_q == word_last_q);
   assign last_beat     = last_word && blk_cnt_en && (blocks_left_q == BLKCNT_W'(1));

   assign beat.beat_ready = (state_q == StRun);
   assign beat.mem_addr   = mem_addr_q;
   assign blocks_left     = blocks_left_q;
   assign busy            = (state_q != StIdle);
   assign dma_int         = dma_int_q;
   assign xfer_done       = xfer_done_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q       <= StIdle;
         mem_addr_q    <= 32'd0;
         blocks_left_q <= '0;
         boundary_q    <= 3'd0;
         word_last_q   <= '0;
         word_cnt_q    <= '0;
         dma_int_q     <= 1'b0;
         xfer_done_q   <= 1'b0;
      end else begin
         dma_int_q   <= 1'b0;
         xfer_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (blk_cnt_en && (block_count == '0)) begin
                     xfer_done_q <= 1'b1;
                  end else begin
                     mem_addr_q    <= init_dma_sys_addr;
                     blocks_left_q <= block_count;
                     boundary_q    <= buf_boundary;
                     word_last_q   <= block_size[BLKSIZE_W-1:2] - WordW'(1);
                     word_cnt_q    <= '0;
                     state_q       <= StRun;
                  end
               end else if (sys_addr_wr) begin
                  mem_addr_q <= sys_addr_wdata;
               end
            end
            StRun: begin
               if (stop) begin
                  state_q     <= StIdle;
                  xfer_done_q <= 1'b1;
               end else if (beat.beat_valid) begin
                  mem_addr_q <= next_addr;
                  if (last_word) begin
                     word_cnt_q <= '0;
                     if (blk_cnt_en) begin
                        blocks_left_q <= blocks_left_q - BLKCNT_W'(1);
                     end
                  end else begin
                     word_cnt_q <= word_cnt_q + WordW'(1);
                  end
                  // Completion takes priority over a coincident boundary crossing.
                  if (last_beat) begin
                     state_q     <= StIdle;
                     xfer_done_q <= 1'b1;
                  end else if (boundary_hit) begin
                     state_q   <= StPause;
                     dma_int_q <= 1'b1;
                  end
               end
            end
            StPause: begin
               if (stop) begin
                  state_q     <= StIdle;
                  xfer_done_q <= 1'b1;
               end else if (sys_addr_wr) begin
                  mem_addr_q <= sys_addr_wdata;
                  state_q    <= StRun;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_emmc_sdma_walker.sv
// Directed self-checking bench for the SDMA walker; inputs change and outputs are sampled
// on the falling clock edge.
module tb_sd_emmc_sdma_walker;

   logic        clock;
   logic        reset;
   logic        start;
   logic        stop;
   logic [31:0] init_dma_sys_addr;
   logic        sys_addr_wr;
   logic [31:0] sys_addr_wdata;
   logic [2:0]  buf_boundary;
   logic [11:0] block_size;
   logic [15:0] block_count;
   logic        blk_cnt_en;
   logic [15:0] blocks_left;
   logic        busy;
   logic        dma_int;
   logic        xfer_done;

   int checks = 0;
   int errors = 0;

   sd_emmc_sdma_walker_if ifc ();

   sd_emmc_sdma_walker #(
      .BLKCNT_W  (16),
      .BLKSIZE_W (12)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .stop              (stop),
      .init_dma_sys_addr (init_dma_sys_addr),
      .sys_addr_wr       (sys_addr_wr),
      .sys_addr_wdata    (sys_addr_wdata),
      .buf_boundary      (buf_boundary),
      .block_size        (block_size),
      .block_count       (block_count),
      .blk_cnt_en        (blk_cnt_en),
      .beat              (ifc.slave),
      .blocks_left       (blocks_left),
      .busy              (busy),
      .dma_int           (dma_int),
      .xfer_done         (xfer_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic [31:0] addr, input logic [2:0] bnd, input logic [11:0] size,
                           input logic [15:0] cnt, input logic en);
      init_dma_sys_addr = addr;
      buf_boundary      = bnd;
      block_size        = size;
      block_count       = cnt;
      blk_cnt_en        = en;
      start             = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Streams beats until dma_int or xfer_done is seen, checking each beat address.
   task automatic run(input logic [31:0] addr0, input int max_cycles, output int beats,
                      output logic got_dma, output logic got_done, output logic addr_ok);
      beats    = 0;
      got_dma  = 1'b0;
      got_done = 1'b0;
      addr_ok  = 1'b1;
      for (int i = 0; i < max_cycles; i++) begin
         if (ifc.beat_ready && ifc.beat_valid) begin
            if (ifc.mem_addr !== addr0 + 32'(4 * beats)) addr_ok = 1'b0;
            beats++;
         end
         @(negedge clock);
         if (dma_int)   begin got_dma = 1'b1;  break; end
         if (xfer_done) begin got_done = 1'b1; break; end
      end
   endtask

   int   beats;
   logic got_dma, got_done, addr_ok, ready_seen;

   initial begin
      reset = 1'b0; start = 1'b0; stop = 1'b0; sys_addr_wr = 1'b0; sys_addr_wdata = '0;
      init_dma_sys_addr = '0; buf_boundary = '0; block_size = 12'd512; block_count = '0;
      blk_cnt_en = 1'b1; ifc.beat_valid = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(ifc.beat_ready), 32'd0);
      chk("rst_addr", ifc.mem_addr, 32'd0);
      chk("rst_blocks", 32'(blocks_left), 32'd0);
      chk("rst_dma", 32'(dma_int), 32'd0);
      chk("rst_done", 32'(xfer_done), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // Address write while idle
      sys_addr_wr = 1'b1; sys_addr_wdata = 32'hABCD_0000;
      @(negedge clock);
      sys_addr_wr = 1'b0;
      chk("idle_wr_addr", ifc.mem_addr, 32'hABCD_0000);
      chk("idle_wr_busy", 32'(busy), 32'd0);

      // One 512-byte block from 0x1000
      ifc.beat_valid = 1'b1;
      do_start(32'h1000, 3'd0, 12'd512, 16'd1, 1'b1);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_ready", 32'(ifc.beat_ready), 32'd1);
      chk("t1_addr0", ifc.mem_addr, 32'h1000);
      run(32'h1000, 300, beats, got_dma, got_done, addr_ok);
      chk("t1_beats", 32'(beats), 32'd128);
      chk("t1_addrs", 32'(addr_ok), 32'd1);
      chk("t1_done", 32'(got_done), 32'd1);
      chk("t1_nodma", 32'(got_dma), 32'd0);
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_final", ifc.mem_addr, 32'h1200);
      chk("t1_blocks", 32'(blocks_left), 32'd0);
      @(negedge clock);
      chk("t1_done_pulse", 32'(xfer_done), 32'd0);

      // Boundary crossing after two beats, resume at 0x8000
      do_start(32'h0FF8, 3'd0, 12'd512, 16'd2, 1'b1);
      run(32'h0FF8, 20, beats, got_dma, got_done, addr_ok);
      chk("t2_beats_a", 32'(beats), 32'd2);
      chk("t2_dma", 32'(got_dma), 32'd1);
      chk("t2_addr_pause", ifc.mem_addr, 32'h1000);
      chk("t2_ready_pause", 32'(ifc.beat_ready), 32'd0);
      chk("t2_blocks_pause", 32'(blocks_left), 32'd2);
      @(negedge clock);
      chk("t2_dma_pulse", 32'(dma_int), 32'd0);
      chk("t2_still_paused", 32'(ifc.beat_ready), 32'd0);
      sys_addr_wr = 1'b1; sys_addr_wdata = 32'h8000;
      @(negedge clock);
      sys_addr_wr = 1'b0;
      chk("t2_resume_ready", 32'(ifc.beat_ready), 32'd1);
      chk("t2_resume_addr", ifc.mem_addr, 32'h8000);
      run(32'h8000, 400, beats, got_dma, got_done, addr_ok);
      chk("t2_beats_b", 32'(beats), 32'd254);
      chk("t2_addrs", 32'(addr_ok), 32'd1);
      chk("t2_done", 32'(got_done), 32'd1);
      chk("t2_blocks_end", 32'(blocks_left), 32'd0);
      chk("t2_final", ifc.mem_addr, 32'h83F8);

      // Last beat coincides with an 8 KiB boundary
      do_start(32'h7E00, 3'd1, 12'd512, 16'd1, 1'b1);
      run(32'h7E00, 300, beats, got_dma, got_done, addr_ok);
      chk("t3_beats", 32'(beats), 32'd128);
      chk("t3_done", 32'(got_done), 32'd1);
      chk("t3_nodma", 32'(got_dma), 32'd0);
      chk("t3_final", ifc.mem_addr, 32'h8000);
      @(negedge clock);
      chk("t3_nodma_late", 32'(dma_int), 32'd0);
      chk("t3_idle", 32'(busy), 32'd0);

      // Zero block count completes immediately
      do_start(32'h4000, 3'd0, 12'd512, 16'd0, 1'b1);
      chk("t4_done", 32'(xfer_done), 32'd1);
      chk("t4_busy", 32'(busy), 32'd0);
      ready_seen = ifc.beat_ready;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         ready_seen = ready_seen | ifc.beat_ready;
      end
      chk("t4_never_ready", 32'(ready_seen), 32'd0);

      // Stop during pause overrides a simultaneous address write
      do_start(32'h0FFC, 3'd0, 12'd512, 16'd4, 1'b1);
      run(32'h0FFC, 20, beats, got_dma, got_done, addr_ok);
      chk("t5_dma", 32'(got_dma), 32'd1);
      chk("t5_pause_addr", ifc.mem_addr, 32'h1000);
      stop = 1'b1; sys_addr_wr = 1'b1; sys_addr_wdata = 32'h5000;
      @(negedge clock);
      stop = 1'b0; sys_addr_wr = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done", 32'(xfer_done), 32'd1);
      chk("t5_addr_held", ifc.mem_addr, 32'h1000);
      chk("t5_blocks_held", 32'(blocks_left), 32'd4);

      // Stop in RUN overrides a same-cycle beat
      do_start(32'h3000, 3'd0, 12'd512, 16'd3, 1'b1);
      repeat (3) @(negedge clock);
      chk("t5b_addr_run", ifc.mem_addr, 32'h300C);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      chk("t5b_done", 32'(xfer_done), 32'd1);
      chk("t5b_addr_held", ifc.mem_addr, 32'h300C);
      chk("t5b_blocks", 32'(blocks_left), 32'd3);

      // Reset mid-run
      do_start(32'h2000, 3'd0, 12'd512, 16'd3, 1'b1);
      repeat (5) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      chk("t5r_busy", 32'(busy), 32'd0);
      chk("t5r_ready", 32'(ifc.beat_ready), 32'd0);
      chk("t5r_addr", ifc.mem_addr, 32'd0);
      chk("t5r_blocks", 32'(blocks_left), 32'd0);
      chk("t5r_dma", 32'(dma_int), 32'd0);
      chk("t5r_done", 32'(xfer_done), 32'd0);
      reset = 1'b1;
      @(negedge clock);

      // Address wrap counts as a boundary crossing
      do_start(32'hFFFF_FFFC, 3'd7, 12'd512, 16'd0, 1'b0);
      run(32'hFFFF_FFFC, 20, beats, got_dma, got_done, addr_ok);
      chk("t6_beats", 32'(beats), 32'd1);
      chk("t6_dma", 32'(got_dma), 32'd1);
      chk("t6_addr", ifc.mem_addr, 32'd0);
      chk("t6_busy", 32'(busy), 32'd1);
      stop = 1'b1;
      @(negedge clock);
      stop = 1'b0;
      chk("t6_stop", 32'(busy), 32'd0);

      ifc.beat_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
